cp0_ctrl: RTL and testbench

//  Coprocessor 0 for the P7 pipelined MIPS core; sits beside the M stage.

---
 rtl/cp0_ctrl_pkg.sv | 30 +++
 rtl/cp0_ctrl_if.sv | 11 +
 rtl/cp0_ctrl.sv | 90 +++++++++
 tb/tb_cp0_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/cp0_ctrl_pkg.sv
// Shared CP0 constants: register numbers, exception codes, field positions,
// handler entry point, and the EPC selection rule for delay slots.
package cp0_ctrl_pkg;

  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int SR_IE        = 0;
  localparam int SR_EXL       = 1;
  localparam int SR_IM_LO     = 10;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_BD     = 31;

  localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;

  // A delay-slot instruction restarts at its branch, one word earlier.
  function automatic logic [31:0] exc_pc(input logic [31:0] pc, input logic bd);
    return bd ? (pc - 32'd4) : pc;
  endfunction

endpackage

// File: rtl/cp0_ctrl_if.sv
// mfc0/mtc0 register bus between the M stage and CP0.
interface cp0_ctrl_if;
  logic [4:0]  A1;    // mfc0 read register
  logic [4:0]  A2;    // mtc0 write register
  logic [31:0] DIn;   // mtc0 write data
  logic        WE;    // mtc0 write enable
  logic [31:0] DOut;  // mfc0 read data

  modport master (output A1, A2, DIn, WE, input DOut);
  modport slave  (input A1, A2, DIn, WE, output DOut);
endinterface

// File: rtl/cp0_ctrl.sv
// Coprocessor 0: SR/Cause/EPC, interrupt/exception request, mfc0/mtc0, eret.
module cp0_ctrl
  import cp0_ctrl_pkg::*;
#(
  parameter int          HWINT_W   = 6,
  parameter logic [31:0] SR_WMASK  = 32'h0000_FC03,
  parameter logic [31:0] EPC_WMASK = 32'hFFFF_FFFC
) (
  input  logic               clk,
  input  logic               reset,      // synchronous, active low
  cp0_ctrl_if.slave          bus,
  input  logic [31:0]        M_PC,
  input  logic               BD,
  input  logic [4:0]         ExcCodeIn,
  input  logic               EXLClr,
  input  logic [HWINT_W-1:0] HWInt,
  output logic               Req,
  output logic [31:0]        EPCOut
);

  logic [31:0] sr_q, sr_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic        int_req, exc_req, mtc0_en;

  // Request decode; EXL masks everything, so nested events are dropped.
  always_comb begin
    int_req = (|(HWInt & sr_q[SR_IM_LO +: HWINT_W])) & sr_q[SR_IE] & ~sr_q[SR_EXL];
    exc_req = (ExcCodeIn != EXC_INT) & ~sr_q[SR_EXL];
    Req     = int_req | exc_req;
    // A faulting mtc0 or an eret in the same cycle blocks the write.
    mtc0_en = bus.WE & ~Req & ~EXLClr;
  end

  // Next-state for SR: Req sets EXL, eret clears it, else mtc0.
  always_comb begin
    sr_d = sr_q;
    if (Req)                             sr_d[SR_EXL] = 1'b1;
    else if (EXLClr)                     sr_d[SR_EXL] = 1'b0;
    else if (mtc0_en && bus.A2 == CP0_SR) sr_d = bus.DIn & SR_WMASK;
  end

  // Next-state for Cause: IP tracks the lines every cycle; BD/ExcCode latch on Req.
  always_comb begin
    cause_d = cause_q;
    cause_d[CAUSE_IP_LO +: HWINT_W] = HWInt;
    if (Req) begin
      cause_d[CAUSE_BD] = BD;
      cause_d[CAUSE_EXC_HI:CAUSE_EXC_LO] = int_req ? EXC_INT : ExcCodeIn;
    end
  end

  // Next-state for EPC: exception PC wins over an mtc0 write.
  always_comb begin
    epc_d = epc_q;
    if (Req)                               epc_d = exc_pc(M_PC, BD) & EPC_WMASK;
    else if (mtc0_en && bus.A2 == CP0_EPC) epc_d = bus.DIn & EPC_WMASK;
  end

  // SR register
  always_ff @(posedge clk) begin
    if (!reset) sr_q <= '0;
    else        sr_q <= sr_d;
  end

  // Cause register
  always_ff @(posedge clk) begin
    if (!reset) cause_q <= '0;
    else        cause_q <= cause_d;
  end

  // EPC register
  always_ff @(posedge clk) begin
    if (!reset) epc_q <= '0;
    else        epc_q <= epc_d;
  end

  // mfc0 read mux, pre-edge state only; forwarding lives in the hazard unit.
  always_comb begin
    case (bus.A1)
      CP0_SR:    bus.DOut = sr_q;
      CP0_CAUSE: bus.DOut = cause_q;
      CP0_EPC:   bus.DOut = epc_q;
      default:   bus.DOut = '0;
    endcase
  end

  assign EPCOut = epc_q;

endmodule

// File: tb/tb_cp0_ctrl.sv
// Bench for cp0_ctrl: directed scenarios plus randomized traffic against a
// register-level model of SR/Cause/EPC.
module tb_cp0_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] M_PC;
  logic        BD;
  logic [4:0]  ExcCodeIn;
  logic        EXLClr;
  logic [5:0]  HWInt;
  logic        Req;
  logic [31:0] EPCOut;

  cp0_ctrl_if bus();

  cp0_ctrl dut (
    .clk(clk), .reset(reset), .bus(bus), .M_PC(M_PC), .BD(BD),
    .ExcCodeIn(ExcCodeIn), .EXLClr(EXLClr), .HWInt(HWInt),
    .Req(Req), .EPCOut(EPCOut)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_sr, m_cause, m_epc;

  function automatic logic m_int();
    return (|(HWInt & m_sr[15:10])) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic m_req();
    return m_int() || ((ExcCodeIn != 5'd0) && !m_sr[1]);
  endfunction

  function automatic logic [31:0] m_dout(input logic [4:0] a);
    if (a == 5'd12) return m_sr;
    if (a == 5'd13) return m_cause;
    if (a == 5'd14) return m_epc;
    return 32'd0;
  endfunction

  // One clock; the model advances from the inputs held across the edge.
  task automatic tick();
    logic [31:0] nsr, nca, nep;
    logic ir, rq;
    ir = m_int();
    rq = m_req();
    nsr = m_sr; nca = m_cause; nep = m_epc;
    if (!reset) begin
      nsr = 0; nca = 0; nep = 0;
    end else begin
      nca[15:10] = HWInt;
      if (rq) begin
        nsr[1] = 1'b1;
        nca[31] = BD;
        nca[6:2] = ir ? 5'd0 : ExcCodeIn;
        nep = (BD ? M_PC - 32'd4 : M_PC) & 32'hFFFF_FFFC;
      end else if (EXLClr) begin
        nsr[1] = 1'b0;
      end else if (bus.WE) begin
        if (bus.A2 == 5'd12) nsr = bus.DIn & 32'h0000_FC03;
        else if (bus.A2 == 5'd14) nep = bus.DIn & 32'hFFFF_FFFC;
      end
    end
    @(posedge clk);
    m_sr = nsr; m_cause = nca; m_epc = nep;
    #1;
  endtask

  task automatic quiet();
    bus.WE = 0; EXLClr = 0; ExcCodeIn = 0; BD = 0;
  endtask

  task automatic test_reset();
    reset = 0; quiet(); HWInt = 0; M_PC = 32'h3000;
    bus.A1 = 0; bus.A2 = 0; bus.DIn = 0;
    tick(); tick();
    for (int r = 12; r <= 14; r++) begin
      bus.A1 = 5'(r); #1;
      checks++; if (bus.DOut !== 32'd0) begin errors++; $display("FAIL reset_dout reg%0d got %h want 0", r, bus.DOut); end
    end
    checks++; if (Req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", Req); end
    checks++; if (EPCOut !== 32'd0) begin errors++; $display("FAIL reset_epc got %h want 0", EPCOut); end
    reset = 1;
  endtask

  task automatic test_interrupt();
    bus.WE = 1; bus.A2 = 12; bus.DIn = 32'h0000_0401; tick(); bus.WE = 0;
    HWInt = 6'b000001; M_PC = 32'h3008; BD = 0; #1;
    checks++; if (Req !== 1'b1) begin errors++; $display("FAIL int_req got %b want 1", Req); end
    tick();
    checks++; if (EPCOut !== 32'h3008) begin errors++; $display("FAIL int_epc got %h want 3008", EPCOut); end
    bus.A1 = 13; #1;
    checks++; if (bus.DOut !== 32'h0000_0400) begin errors++; $display("FAIL int_cause got %h want 00000400", bus.DOut); end
    bus.A1 = 12; #1;
    checks++; if (bus.DOut !== 32'h0000_0403) begin errors++; $display("FAIL int_sr got %h want 00000403", bus.DOut); end
    checks++; if (Req !== 1'b0) begin errors++; $display("FAIL int_masked got %b want 0", Req); end
  endtask

  task automatic test_delay_slot();
    HWInt = 0; EXLClr = 1; tick(); EXLClr = 0;
    ExcCodeIn = 12; M_PC = 32'h3010; BD = 1; #1;
    checks++; if (Req !== 1'b1) begin errors++; $display("FAIL ds_req got %b want 1", Req); end
    tick(); quiet();
    checks++; if (EPCOut !== 32'h300C) begin errors++; $display("FAIL ds_epc got %h want 300c", EPCOut); end
    bus.A1 = 13; #1;
    checks++; if (bus.DOut !== 32'h8000_0030) begin errors++; $display("FAIL ds_cause got %h want 80000030", bus.DOut); end
  endtask

  task automatic test_back_to_back();
    EXLClr = 1; tick(); EXLClr = 0;
    ExcCodeIn = 5; M_PC = 32'h3020; bus.WE = 1; bus.A2 = 14; bus.DIn = 32'h5000;
    tick(); quiet();
    checks++; if (EPCOut !== 32'h3020) begin errors++; $display("FAIL simul_epc got %h want 3020", EPCOut); end
    bus.A1 = 13; #1;
    checks++; if (bus.DOut !== 32'h0000_0014) begin errors++; $display("FAIL simul_cause got %h want 00000014", bus.DOut); end
    // Req together with eret: EXL must end up set.
    EXLClr = 1; tick(); EXLClr = 0;
    ExcCodeIn = 10; EXLClr = 1; M_PC = 32'h3030; tick(); quiet();
    bus.A1 = 12; #1;
    checks++; if (bus.DOut !== 32'h0000_0403) begin errors++; $display("FAIL req_eret_sr got %h want 00000403", bus.DOut); end
    checks++; if (EPCOut !== 32'h3030) begin errors++; $display("FAIL req_eret_epc got %h want 3030", EPCOut); end
  endtask

  task automatic test_eret();
    HWInt = 6'b000001; EXLClr = 1; bus.WE = 1; bus.A2 = 12; bus.DIn = 32'hFFFF_FFFF; #1;
    checks++; if (Req !== 1'b0) begin errors++; $display("FAIL eret_req_during got %b want 0", Req); end
    tick(); quiet();
    bus.A1 = 12; #1;
    checks++; if (bus.DOut !== 32'h0000_0401) begin errors++; $display("FAIL eret_sr got %h want 00000401", bus.DOut); end
    checks++; if (Req !== 1'b1) begin errors++; $display("FAIL eret_pending got %b want 1", Req); end
    M_PC = 32'h3040; tick(); HWInt = 0;
    checks++; if (EPCOut !== 32'h3040) begin errors++; $display("FAIL eret_int_epc got %h want 3040", EPCOut); end
  endtask

  task automatic test_masking();
    ExcCodeIn = 4; M_PC = 32'h3100; #1;
    checks++; if (Req !== 1'b0) begin errors++; $display("FAIL mask_req got %b want 0", Req); end
    tick(); quiet();
    checks++; if (EPCOut !== 32'h3040) begin errors++; $display("FAIL mask_epc got %h want 3040", EPCOut); end
    HWInt = 6'b101010; bus.WE = 1; bus.A2 = 13; bus.DIn = 32'hFFFF_FFFF; tick();
    bus.A1 = 13; #1;
    checks++; if (bus.DOut !== 32'h0000_A800) begin errors++; $display("FAIL cause_ro got %h want 0000a800", bus.DOut); end
    bus.A2 = 14; bus.DIn = 32'h0000_1237; tick();
    checks++; if (EPCOut !== 32'h0000_1234) begin errors++; $display("FAIL epc_align got %h want 00001234", EPCOut); end
    bus.A2 = 3; bus.DIn = 32'h0; tick();
    bus.A2 = 12; bus.DIn = 32'hFFFF_FFFF; HWInt = 0; tick(); quiet();
    bus.A1 = 12; #1;
    checks++; if (bus.DOut !== 32'h0000_FC03) begin errors++; $display("FAIL sr_wmask got %h want 0000fc03", bus.DOut); end
    bus.A1 = 3; #1;
    checks++; if (bus.DOut !== 32'd0) begin errors++; $display("FAIL unmapped_read got %h want 0", bus.DOut); end
  endtask

  task automatic test_random();
    logic [4:0] codes [4];
    codes[0] = 4; codes[1] = 5; codes[2] = 10; codes[3] = 12;
    reset = 0; quiet(); tick(); reset = 1;
    for (int i = 0; i < 500; i++) begin
      reset     = ($urandom_range(49) != 0);
      bus.WE    = ($urandom_range(2) == 0);
      case ($urandom_range(3))
        0: bus.A2 = 12; 1: bus.A2 = 13; 2: bus.A2 = 14; default: bus.A2 = 5'($urandom);
      endcase
      case ($urandom_range(3))
        0: bus.A1 = 12; 1: bus.A1 = 13; 2: bus.A1 = 14; default: bus.A1 = 5'($urandom);
      endcase
      bus.DIn   = $urandom;
      ExcCodeIn = ($urandom_range(3) == 0) ? codes[$urandom_range(3)] : 5'd0;
      EXLClr    = ($urandom_range(5) == 0);
      HWInt     = ($urandom_range(2) == 0) ? 6'($urandom) : 6'd0;
      BD        = 1'($urandom);
      M_PC      = $urandom;
      #1;
      checks++; if (Req !== m_req()) begin errors++; $display("FAIL rnd_req cyc%0d got %b want %b", i, Req, m_req()); end
      checks++; if (bus.DOut !== m_dout(bus.A1)) begin errors++; $display("FAIL rnd_dout cyc%0d a1=%0d got %h want %h", i, bus.A1, bus.DOut, m_dout(bus.A1)); end
      checks++; if (EPCOut !== m_epc) begin errors++; $display("FAIL rnd_epc cyc%0d got %h want %h", i, EPCOut, m_epc); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_interrupt();
    test_delay_slot();
    test_back_to_back();
    test_eret();
    test_masking();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
